// File: rtl/i2c_slave_ctrl.sv
// 7-bit-address I2C slave: oversamples SCL/SDA on clk_sys and bridges master
// writes into an RX FIFO and master reads from a first-word-fall-through TX FIFO.
module i2c_slave_ctrl #(
  parameter logic [6:0]  G_SLAVE_ADDR  = 7'h50,
  parameter int unsigned G_SYNC_STAGES = 2
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_sys,
  input  logic       i_sclk,
  input  logic       i_sda_in,
  output logic       o_sda_en,
  output logic       o_wr_en_rx,
  output logic [7:0] o_wdata_rx,
  input  logic       i_fifo_full_rx,
  output logic       o_rd_en_tx,
  input  logic [7:0] i_rdata_tx,
  input  logic       i_fifo_empty_tx,
  output logic       o_busy,
  output logic       o_start_det,
  output logic       o_stop_det,
  output logic       o_rx_overflow,
  output logic       o_tx_underflow
);

  localparam int unsigned C_BYTE_W  = 8;
  localparam int unsigned C_CNT_W   = 3;
  localparam int unsigned C_STATE_W = 3;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ACK_ADDR  = 3'd2;
  localparam logic [2:0] S_WR_BYTE   = 3'd3;
  localparam logic [2:0] S_ACK_WR    = 3'd4;
  localparam logic [2:0] S_RD_BYTE   = 3'd5;
  localparam logic [2:0] S_ACK_RD    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [G_SYNC_STAGES-1:0] r_scl_sync;
  logic [G_SYNC_STAGES-1:0] r_sda_sync;
  logic                     r_scl_q;
  logic                     r_sda_q;

  logic w_scl_r;
  logic w_sda_r;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  logic [C_STATE_W-1:0] r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_byte_done;
  logic [C_BYTE_W-1:0]  r_shift;
  logic                 r_rw;
  logic                 r_mack;
  logic                 r_sda_en;
  logic                 r_busy;
  logic [C_BYTE_W-1:0]  r_wdata;
  logic                 r_wr_en;
  logic                 r_rd_en;
  logic                 r_start_det;
  logic                 r_stop_det;
  logic                 r_rx_ovf;
  logic                 r_tx_unf;

  logic [C_STATE_W-1:0] w_state_nxt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_byte_done_nxt;
  logic [C_BYTE_W-1:0]  w_shift_nxt;
  logic                 w_rw_nxt;
  logic                 w_mack_nxt;
  logic                 w_sda_en_nxt;
  logic                 w_busy_nxt;
  logic [C_BYTE_W-1:0]  w_wdata_nxt;
  logic                 w_wr_en_nxt;
  logic                 w_rd_en_nxt;
  logic                 w_start_det_nxt;
  logic                 w_stop_det_nxt;
  logic                 w_rx_ovf_nxt;
  logic                 w_tx_unf_nxt;
  logic [C_BYTE_W-1:0]  w_load_byte;

  // Pad synchronizers plus one history stage; reset to the idle-high bus level
  always_ff @(posedge i_clk_sys) begin
    if (i_rst_sys) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[G_SYNC_STAGES-2:0], i_sclk};
      r_sda_sync <= {r_sda_sync[G_SYNC_STAGES-2:0], i_sda_in};
      r_scl_q    <= r_scl_sync[G_SYNC_STAGES-1];
      r_sda_q    <= r_sda_sync[G_SYNC_STAGES-1];
    end
  end

  assign w_scl_r    = r_scl_sync[G_SYNC_STAGES-1];
  assign w_sda_r    = r_sda_sync[G_SYNC_STAGES-1];
  assign w_scl_rise = w_scl_r & ~r_scl_q;
  assign w_scl_fall = ~w_scl_r & r_scl_q;
  assign w_start    = w_scl_r & r_sda_q & ~w_sda_r;
  assign w_stop     = w_scl_r & ~r_sda_q & w_sda_r;

  // An empty TX FIFO is answered with 0xFF so the master still sees a full byte
  assign w_load_byte = i_fifo_empty_tx ? 8'hFF : i_rdata_tx;

  always_ff @(posedge i_clk_sys) begin
    if (i_rst_sys) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_byte_done <= 1'b0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_sda_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_unf    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_mack      <= w_mack_nxt;
      r_sda_en    <= w_sda_en_nxt;
      r_busy      <= w_busy_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_start_det <= w_start_det_nxt;
      r_stop_det  <= w_stop_det_nxt;
      r_rx_ovf    <= w_rx_ovf_nxt;
      r_tx_unf    <= w_tx_unf_nxt;
    end
  end

  // Bus conditions override any bit event seen in the same cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_byte_done_nxt = r_byte_done;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_mack_nxt      = r_mack;
    w_sda_en_nxt    = r_sda_en;
    w_busy_nxt      = r_busy;
    w_wdata_nxt     = r_wdata;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_start_det_nxt = 1'b0;
    w_stop_det_nxt  = 1'b0;
    w_rx_ovf_nxt    = 1'b0;
    w_tx_unf_nxt    = 1'b0;

    if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_cnt_nxt       = '0;
      w_byte_done_nxt = 1'b0;
      w_sda_en_nxt    = 1'b0;
      w_start_det_nxt = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = S_IDLE;
      w_cnt_nxt       = '0;
      w_byte_done_nxt = 1'b0;
      w_sda_en_nxt    = 1'b0;
      w_busy_nxt      = 1'b0;
      w_stop_det_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt     = {r_shift[C_BYTE_W-2:0], w_sda_r};
            w_cnt_nxt       = r_cnt + 3'd1;
            w_byte_done_nxt = (r_cnt == 3'd7);
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            w_cnt_nxt       = '0;
            if (r_shift[7:1] == G_SLAVE_ADDR) begin
              w_state_nxt  = S_ACK_ADDR;
              w_sda_en_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
              w_rw_nxt     = r_shift[0];
            end else begin
              w_state_nxt  = S_WAIT_STOP;
              w_sda_en_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
            end
          end
        end
        S_ACK_ADDR: begin
          if (w_scl_fall) begin
            w_cnt_nxt = '0;
            if (!r_rw) begin
              w_state_nxt  = S_WR_BYTE;
              w_sda_en_nxt = 1'b0;
            end else begin
              w_state_nxt  = S_RD_BYTE;
              w_shift_nxt  = w_load_byte;
              w_rd_en_nxt  = ~i_fifo_empty_tx;
              w_tx_unf_nxt = i_fifo_empty_tx;
              w_sda_en_nxt = ~w_load_byte[7];
            end
          end
        end
        S_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt     = {r_shift[C_BYTE_W-2:0], w_sda_r};
            w_cnt_nxt       = r_cnt + 3'd1;
            w_byte_done_nxt = (r_cnt == 3'd7);
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            w_cnt_nxt       = '0;
            if (!i_fifo_full_rx) begin
              w_state_nxt  = S_ACK_WR;
              w_wr_en_nxt  = 1'b1;
              w_wdata_nxt  = r_shift;
              w_sda_en_nxt = 1'b1;
            end else begin
              w_state_nxt  = S_WAIT_STOP;
              w_rx_ovf_nxt = 1'b1;
              w_sda_en_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
            end
          end
        end
        S_ACK_WR: begin
          if (w_scl_fall) begin
            w_state_nxt  = S_WR_BYTE;
            w_sda_en_nxt = 1'b0;
          end
        end
        S_RD_BYTE: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_state_nxt  = S_ACK_RD;
              w_cnt_nxt    = '0;
              w_sda_en_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[C_BYTE_W-2:0], 1'b1};
              w_sda_en_nxt = ~r_shift[C_BYTE_W-2];
              w_cnt_nxt    = r_cnt + 3'd1;
            end
          end
        end
        S_ACK_RD: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda_r;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_state_nxt  = S_RD_BYTE;
              w_cnt_nxt    = '0;
              w_shift_nxt  = w_load_byte;
              w_rd_en_nxt  = ~i_fifo_empty_tx;
              w_tx_unf_nxt = i_fifo_empty_tx;
              w_sda_en_nxt = ~w_load_byte[7];
            end else begin
              w_state_nxt  = S_WAIT_STOP;
              w_sda_en_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
            end
          end
        end
        default: begin
          w_sda_en_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_sda_en       = r_sda_en;
  assign o_wr_en_rx     = r_wr_en;
  assign o_wdata_rx     = r_wdata;
  assign o_rd_en_tx     = r_rd_en;
  assign o_busy         = r_busy;
  assign o_start_det    = r_start_det;
  assign o_stop_det     = r_stop_det;
  assign o_rx_overflow  = r_rx_ovf;
  assign o_tx_underflow = r_tx_unf;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: a bit-level I2C master, FIFO models and a
// transaction-level reference model for directed and random transfers.
module tb_i2c_slave_ctrl;

  localparam int unsigned Q   = 8;
  localparam logic [6:0]  SLV = 7'h50;

  typedef struct {
    logic [6:0]       addr;
    logic             rw;
    int               nbytes;
    logic [3:0][7:0]  d;
    int               full_at;
    int               tx_avail;
  } txn_t;

  typedef struct {
    logic             addr_ack;
    int               n_push;
    logic [3:0][7:0]  push_d;
    int               n_pop;
    int               n_ovf;
    int               n_unf;
    int               n_start;
    int               n_stop;
    logic             busy_seen;
    logic             busy_end;
    logic             sda_seen;
    logic [3:0][7:0]  rd_d;
  } obs_t;

  typedef struct {
    string name;
    txn_t  t;
    obs_t  e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       line_sda;
  logic       sda_en;
  logic       wr_en;
  logic [7:0] wdata;
  logic       fifo_full;
  logic       rd_en;
  logic [7:0] rdata;
  logic       fifo_empty;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  logic       rx_ovf;
  logic       tx_unf;

  logic [7:0] tx_mem [64];
  logic [5:0] tx_wr = 6'd0;
  logic [5:0] tx_rd = 6'd0;

  int c_push = 0, c_pop = 0, c_start = 0, c_stop = 0;
  int c_ovf = 0, c_unf = 0, c_busy = 0, c_sda = 0;
  logic [7:0] push_log[$];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign line_sda   = m_sda & ~sda_en;
  assign fifo_empty = (tx_wr == tx_rd);
  assign rdata      = tx_mem[tx_rd];

  i2c_slave_ctrl #(.G_SLAVE_ADDR(SLV), .G_SYNC_STAGES(2)) dut (
    .i_clk_sys       (clk),
    .i_rst_sys       (rst),
    .i_sclk          (m_scl),
    .i_sda_in        (line_sda),
    .o_sda_en        (sda_en),
    .o_wr_en_rx      (wr_en),
    .o_wdata_rx      (wdata),
    .i_fifo_full_rx  (fifo_full),
    .o_rd_en_tx      (rd_en),
    .i_rdata_tx      (rdata),
    .i_fifo_empty_tx (fifo_empty),
    .o_busy          (busy),
    .o_start_det     (start_det),
    .o_stop_det      (stop_det),
    .o_rx_overflow   (rx_ovf),
    .o_tx_underflow  (tx_unf)
  );

  // Event counters and FIFO side effects, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_en) begin
      c_push = c_push + 1;
      push_log.push_back(wdata);
    end
    if (rd_en) begin
      c_pop = c_pop + 1;
      tx_rd = tx_rd + 6'd1;
    end
    if (start_det) c_start = c_start + 1;
    if (stop_det)  c_stop  = c_stop + 1;
    if (rx_ovf)    c_ovf   = c_ovf + 1;
    if (tx_unf)    c_unf   = c_unf + 1;
    if (busy)      c_busy  = c_busy + 1;
    if (sda_en)    c_sda   = c_sda + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wq();
    m_scl = 1'b1; wq();
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    b = line_sda; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(nack);
  endtask

  // Transaction-level expectation derived from the bus rules, not the FSM
  function automatic obs_t model(input txn_t t);
    obs_t e;
    e = '{default: '0};
    e.addr_ack  = (t.addr == SLV);
    e.n_start   = 1;
    e.n_stop    = 1;
    e.busy_seen = e.addr_ack;
    e.sda_seen  = e.addr_ack;
    e.busy_end  = 1'b0;
    if (e.addr_ack && !t.rw) begin
      e.n_push = (t.full_at < t.nbytes) ? t.full_at : t.nbytes;
      e.n_ovf  = (t.full_at < t.nbytes) ? 1 : 0;
      for (int i = 0; i < e.n_push; i++) e.push_d[i] = t.d[i];
    end else if (e.addr_ack) begin
      for (int i = 0; i < t.nbytes; i++) begin
        if (i < t.tx_avail) begin
          e.rd_d[i] = t.d[i];
          e.n_pop++;
        end else begin
          e.rd_d[i] = 8'hFF;
          e.n_unf++;
        end
      end
    end
    return e;
  endfunction

  task automatic run_txn(input txn_t t, output obs_t o);
    int b_push, b_pop, b_start, b_stop, b_ovf, b_unf, b_busy, b_sda, b_log;
    logic nack;
    logic [7:0] rb;
    o = '{default: '0};
    b_push = c_push; b_pop = c_pop; b_start = c_start; b_stop = c_stop;
    b_ovf = c_ovf; b_unf = c_unf; b_busy = c_busy; b_sda = c_sda;
    b_log = push_log.size();
    tx_wr = tx_rd;
    if (t.rw) begin
      for (int i = 0; i < t.tx_avail; i++) begin
        tx_mem[tx_wr] = t.d[i];
        tx_wr = tx_wr + 6'd1;
      end
    end
    i2c_start();
    write_byte({t.addr, t.rw}, nack);
    o.addr_ack = ~nack;
    if (!nack) begin
      if (!t.rw) begin
        for (int i = 0; i < t.nbytes; i++) begin
          if (i == t.full_at) fifo_full = 1'b1;
          write_byte(t.d[i], nack);
          if (nack) break;
        end
      end else begin
        for (int i = 0; i < t.nbytes; i++) begin
          read_byte(rb, (i == t.nbytes - 1));
          o.rd_d[i] = rb;
        end
      end
    end
    i2c_stop();
    repeat (4 * Q) @(negedge clk);
    fifo_full = 1'b0;
    tx_wr = tx_rd;
    o.n_push    = c_push - b_push;
    o.n_pop     = c_pop - b_pop;
    o.n_start   = c_start - b_start;
    o.n_stop    = c_stop - b_stop;
    o.n_ovf     = c_ovf - b_ovf;
    o.n_unf     = c_unf - b_unf;
    o.busy_seen = (c_busy != b_busy);
    o.sda_seen  = (c_sda != b_sda);
    o.busy_end  = busy;
    for (int i = 0; i < o.n_push && i < 4; i++) o.push_d[i] = push_log[b_log + i];
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".addr_ack"},  32'(a.addr_ack),  32'(e.addr_ack));
    chk({tag, ".n_push"},    a.n_push,         e.n_push);
    chk({tag, ".push_data"}, a.push_d,         e.push_d);
    chk({tag, ".n_pop"},     a.n_pop,          e.n_pop);
    chk({tag, ".rx_ovf"},    a.n_ovf,          e.n_ovf);
    chk({tag, ".tx_unf"},    a.n_unf,          e.n_unf);
    chk({tag, ".start_det"}, a.n_start,        e.n_start);
    chk({tag, ".stop_det"},  a.n_stop,         e.n_stop);
    chk({tag, ".busy_seen"}, 32'(a.busy_seen), 32'(e.busy_seen));
    chk({tag, ".busy_end"},  32'(a.busy_end),  32'(e.busy_end));
    chk({tag, ".sda_drive"}, 32'(a.sda_seen),  32'(e.sda_seen));
    chk({tag, ".read_data"}, a.rd_d,           e.rd_d);
  endtask

  vec_t vecs[5];

  initial begin
    obs_t o;
    txn_t t;
    logic nack;
    logic b;
    logic [7:0] rb;
    int bs, bst, bu, bp, bpu, bl;

    // {addr, rw, nbytes, data/TX contents, full_at, tx_avail} -> expected observation
    vecs[0] = '{"wr_two",   '{7'h50, 1'b0, 2, 32'h00003CA5, 9, 0},
                '{1'b1, 2, 32'h00003CA5, 0, 0, 0, 1, 1, 1'b1, 1'b0, 1'b1, 32'h0}};
    vecs[1] = '{"wr_nack",  '{7'h51, 1'b0, 1, 32'h000000A5, 9, 0},
                '{1'b0, 0, 32'h0, 0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0, 32'h0}};
    vecs[2] = '{"rd_three", '{7'h50, 1'b1, 3, 32'h00332211, 9, 3},
                '{1'b1, 0, 32'h0, 3, 0, 0, 1, 1, 1'b1, 1'b0, 1'b1, 32'h00332211}};
    vecs[3] = '{"wr_full",  '{7'h50, 1'b0, 2, 32'h00008877, 1, 0},
                '{1'b1, 1, 32'h00000077, 0, 1, 0, 1, 1, 1'b1, 1'b0, 1'b1, 32'h0}};
    vecs[4] = '{"rd_short", '{7'h50, 1'b1, 2, 32'h000000C3, 9, 1},
                '{1'b1, 0, 32'h0, 1, 0, 1, 1, 1, 1'b1, 1'b0, 1'b1, 32'h0000FFC3}};

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({sda_en, wr_en, wdata, rd_en, busy, start_det, stop_det, rx_ovf, tx_unf}), 32'h0);
    rst = 1'b0;
    repeat (2 * Q) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].t, o);
      cmp_obs(vecs[i].name, o, vecs[i].e);
    end

    // Write one byte, repeated START, then read from an empty TX FIFO
    bs = c_start; bst = c_stop; bu = c_unf; bp = c_pop; bpu = c_push; bl = push_log.size();
    tx_wr = tx_rd;
    i2c_start();
    write_byte({SLV, 1'b0}, nack);
    chk("rs.addr_w_ack", 32'(nack), 32'h0);
    write_byte(8'h5A, nack);
    chk("rs.data_ack", 32'(nack), 32'h0);
    i2c_rstart();
    write_byte({SLV, 1'b1}, nack);
    chk("rs.addr_r_ack", 32'(nack), 32'h0);
    chk("rs.busy_held", 32'(busy), 32'h1);
    read_byte(rb, 1'b1);
    chk("rs.read_ff", 32'(rb), 32'hFF);
    i2c_stop();
    repeat (4 * Q) @(negedge clk);
    chk("rs.start_cnt", c_start - bs, 2);
    chk("rs.stop_cnt", c_stop - bst, 1);
    chk("rs.tx_unf", c_unf - bu, 1);
    chk("rs.no_pop", c_pop - bp, 0);
    chk("rs.push_cnt", c_push - bpu, 1);
    if (push_log.size() > bl) chk("rs.push_data", 32'(push_log[bl]), 32'h5A);
    else chk("rs.push_missing", 32'(push_log.size()), 32'(bl + 1));
    chk("rs.busy_end", 32'(busy), 32'h0);

    // Reset asserted while the slave drives bit 4 of a read byte
    tx_wr = tx_rd;
    tx_mem[tx_wr] = 8'h00;
    tx_wr = tx_wr + 6'd1;
    i2c_start();
    write_byte({SLV, 1'b1}, nack);
    chk("rst.addr_ack", 32'(nack), 32'h0);
    for (int i = 0; i < 3; i++) read_bit(b);
    m_sda = 1'b1;
    wq();
    chk("rst.pre_drive", 32'(sda_en), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.sda_release", 32'(sda_en), 32'h0);
    chk("rst.outputs_zero",
        32'({sda_en, wr_en, rd_en, busy, start_det, stop_det, rx_ovf, tx_unf}), 32'h0);
    tx_wr = tx_rd;
    repeat (2 * Q) @(negedge clk);
    run_txn(vecs[0].t, o);
    cmp_obs("post_rst", o, vecs[0].e);

    // Random transfers against the transaction model
    for (int k = 0; k < 10; k++) begin
      t.addr     = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLV;
      t.rw       = 1'($urandom);
      t.nbytes   = int'($urandom_range(1, 4));
      t.d        = 32'($urandom);
      t.full_at  = int'($urandom_range(0, 6));
      t.tx_avail = int'($urandom_range(0, 4));
      run_txn(t, o);
      cmp_obs($sformatf("rand%0d", k), o, model(t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

Synthesizable 7-bit-address I2C slave (responder) that oversamples SCL/SDA on the system clock and bridges I2C transfers to byte FIFOs. It is the counterpart of the `i2c_master` block: master writes are pushed into an RX FIFO, and master reads are served from a TX FIFO. It sits behind the board-level open-drain pads; `sda_en` pulls SDA low and SCL is input-only (no clock stretching).

## Interface
- `G_SLAVE_ADDR`, default 7'h50: 7-bit address this slave answers to.
- `G_SYNC_STAGES`, default 2: synchronizer depth on `sclk` and `sda_in`; legal range 2..3.
- `clk_sys` in 1: system clock. Must be ≥ 16× the SCL frequency.
- `rst_sys` in 1: synchronous reset, active-high.
- `sclk` in 1: I2C SCL as seen on the pad, asynchronous.
- `sda_in` in 1: I2C SDA as seen on the pad, asynchronous.
- `sda_en` out 1: 1 = drive SDA low; 0 = release the line.
- `wr_en_rx` out 1: one-cycle push strobe to the RX FIFO.
- `wdata_rx` out 8: byte received from the master, valid while `wr_en_rx`=1.
- `fifo_full_rx` in 1: RX FIFO full.
- `rd_en_tx` out 1: one-cycle pop strobe to the TX FIFO.
- `rdata_tx` in 8: TX FIFO head, first-word-fall-through, valid while `fifo_empty_tx`=0.
- `fifo_empty_tx` in 1: TX FIFO empty.
- `busy` out 1: 1 from an addressed START until STOP or NACK exit.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `rx_overflow` out 1: one-cycle pulse when a write byte is NACKed because the RX FIFO is full.
- `tx_underflow` out 1: one-cycle pulse when 0xFF is sent because the TX FIFO is empty.

## Operation
- **Front end.** `sclk` and `sda_in` each pass through a `G_SYNC_STAGES` FF synchronizer plus one history FF, giving `scl_r`/`scl_q` and `sda_r`/`sda_q`.
  - rise/fall = edge between q and r.
  - START = `sda` fall while `scl_r`=1. STOP = `sda` rise while `scl_r`=1.
- **States.** IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, ACK_RD, WAIT_STOP.
- **Bits.** A 3-bit counter and an 8-bit shift register, MSB first. Data is sampled on SCL rise; `sda_en` is updated only on SCL fall.
- **START** (any state): go to ADDR, clear the bit counter, release SDA, pulse `start_det`.
- **STOP** (any state): go to IDLE, release SDA, clear `busy`, pulse `stop_det`.
- **ADDR.** After 8 bits, on SCL fall:
  - shift[7:1] == `G_SLAVE_ADDR` → ACK_ADDR, drive SDA low, set `busy`.
  - otherwise → WAIT_STOP with SDA released.
- **ACK_ADDR.** On the next SCL fall:
  - R/W=0 → WR_BYTE, release SDA.
  - R/W=1 → RD_BYTE and load the shift register from `rdata_tx`, pulsing `rd_en_tx`. If the FIFO is empty, load 0xFF with no pop and pulse `tx_underflow`. Drive bit 7 (`sda_en` = ~bit).
- **WR_BYTE.** After the 8th rising edge, on SCL fall:
  - `fifo_full_rx`=0 → pulse `wr_en_rx` with `wdata_rx`=byte, drive ACK, go to ACK_WR.
  - `fifo_full_rx`=1 → no push, leave SDA released (NACK), pulse `rx_overflow`, go to WAIT_STOP.
- **ACK_WR.** On SCL fall: release SDA, return to WR_BYTE.
- **RD_BYTE.** On each SCL fall, shift out the next bit. After the 8th bit's fall, release SDA and go to ACK_RD.
- **ACK_RD.** Sample master ACK on SCL rise:
  - ACK (0) → on SCL fall, load the next byte (same pop/underflow rule) and go to RD_BYTE.
  - NACK → WAIT_STOP.
- **WAIT_STOP.** SDA is released; only START or STOP exit this state.
- **Edge priority.** START/STOP detection takes priority over a bit event in the same cycle.

## Timing
- **Reset.** All outputs are 0 in the cycle after `rst_sys` is sampled high; the state is IDLE. Reset mid-transfer releases SDA immediately, with no FIFO strobe.
- **Input latency.** Pad edge → internal edge detect takes `G_SYNC_STAGES`+1 cycles.
- **SDA output latency.** `sda_en` changes 1 cycle after the detected SCL fall, which is `G_SYNC_STAGES`+2 cycles after the pad fall. This provides the SDA hold time.
- **FIFO strobes.** `wr_en_rx` and `rd_en_tx` are single-cycle and asserted in the same cycle as the `sda_en` update for the ACK/first bit. `wdata_rx` is registered and held until the next push.
- **Status pulses.** `start_det`, `stop_det`, `rx_overflow` and `tx_underflow` are each 1 cycle wide, asserted the cycle after detection.
- **Repeated START.** Re-enters ADDR with no STOP pulse. `busy` stays 1 only if the new address matches.

## Test plan
- Write 0x50 (addr 0x50) with bytes 0xA5, 0x3C, then STOP → address ACK and both bytes ACKed; two `wr_en_rx` pulses with 0xA5 then 0x3C; `stop_det`=1; `busy`=0.
- Write to addr 0x51 → NACK on the address bit; no FIFO strobes; SDA released until STOP; `busy` never 1.
- Read 3 bytes with TX FIFO holding 0x11, 0x22, 0x33 and master NACK on the last byte → SDA carries 0x11, 0x22, 0x33; three `rd_en_tx` pulses; WAIT_STOP until STOP.
- Write 2 bytes with `fifo_full_rx`=1 before the second byte → first byte ACKed and pushed; second byte NACKed; `rx_overflow` pulses once; 1 push total.
- Write 1 byte, repeated START, then read 1 byte from an empty TX FIFO → `start_det` pulses twice; 0xFF driven; `tx_underflow`=1; `rd_en_tx` never asserted.
- Assert `rst_sys` during bit 4 of a read → `sda_en`=0 next cycle; state IDLE; a following full write transaction completes correctly.
